// File: rtl/mips_state_dumper.sv
// mips_state_dumper: on start, freezes the MIPS core and streams every
// register-file entry, then every data-memory word, over a valid/ready port.
//
// Optional feature macro: DUMP_CHECKSUM_EN. When defined, a 32-bit running
// sum of all dumped words is appended as a final word (out_src=2).
//
// Ports:
//   clk, reset (async, active-low)   clock / reset shared with the core
//   start                            dump request (sampled in IDLE only)
//   hold_cpu, busy, done             core freeze, activity flag, done pulse
//   rf_addr / rf_data                register-file debug read port
//   dm_addr / dm_data                data-memory debug read port
//   out_valid/out_ready/out_data     word stream toward debug bridge
//   out_src, out_last                word source (0 reg,1 mem,2 sum), final flag
module mips_state_dumper #(
  parameter int NUM_REGS   = 32,
  parameter int DMEM_WORDS = 64,
  parameter int DMEM_AW    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               hold_cpu,
  output logic               busy,
  output logic               done,
  output logic [4:0]         rf_addr,
  input  logic [31:0]        rf_data,
  output logic [DMEM_AW-1:0] dm_addr,
  input  logic [31:0]        dm_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [1:0]         out_src,
  output logic               out_last
);

  // idx must cover both the register index and the memory word address
  localparam int IW = ((DMEM_AW > 5) ? DMEM_AW : 5) + 1;
  localparam logic [IW-1:0] REG_LAST = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] MEM_LAST = IW'(DMEM_WORDS - 1);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_REG, S_MEM, S_SUM, S_DONE} state_t;
  logic [31:0] acc;
`else
  typedef enum logic [2:0] {S_IDLE, S_REG, S_MEM, S_DONE} state_t;
`endif

  state_t        state;
  logic [IW-1:0] idx;
  logic          slot_free;

  // Output register can be refilled when empty or being drained this cycle
  assign slot_free = !out_valid || out_ready;

  assign rf_addr = (state == S_REG) ? idx[4:0] : 5'd0;
  assign dm_addr = (state == S_MEM) ? idx[DMEM_AW-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      hold_cpu  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REG;
            idx      <= '0;
            hold_cpu <= 1'b1;
            busy     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            acc      <= '0;
`endif
          end
        end
        S_REG: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_data  <= rf_data;
            out_src   <= 2'd0;
            out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc       <= acc + rf_data;
`endif
            if (idx == REG_LAST) begin
              idx   <= '0;
              state <= S_MEM;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_MEM: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_data  <= dm_data;
            out_src   <= 2'd1;
`ifdef DUMP_CHECKSUM_EN
            acc       <= acc + dm_data;
`endif
            if (idx == MEM_LAST) begin
              idx <= '0;
`ifdef DUMP_CHECKSUM_EN
              out_last <= 1'b0;   // checksum word follows
              state    <= S_SUM;
`else
              out_last <= 1'b1;
              state    <= S_DONE;
`endif
            end else begin
              out_last <= 1'b0;
              idx      <= idx + IW'(1);
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_SUM: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_data  <= acc;
            out_src   <= 2'd2;
            out_last  <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // release the core only once the final word has left the block
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            hold_cpu  <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_state_dumper.sv
module tb_mips_state_dumper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        hold_cpu, busy, done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [5:0]  dm_addr;
  logic [31:0] dm_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_src;

  mips_state_dumper #(.NUM_REGS(32), .DMEM_WORDS(64), .DMEM_AW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .hold_cpu(hold_cpu), .busy(busy),
    .done(done), .rf_addr(rf_addr), .rf_data(rf_data), .dm_addr(dm_addr),
    .dm_data(dm_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // memory models
  assign rf_data = 32'(rf_addr) * 32'd3;
  assign dm_data = 32'h1000 + 32'(dm_addr);

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic        last;
    int          cyc;   // -1 = cycle not checked
  } exp_t;

  exp_t q[$];
  int   nchk = 0, nfail = 0;
  int   cyc = 0, nwords = 0, done_cnt = 0;
  int   mode = 0;       // 0 ready=1, 1 random ready, 2 manual
  logic stall_pend = 1'b0;
  logic [31:0] sd;
  logic [1:0]  ss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (mode == 0) out_ready = 1'b1;
    else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (stall_pend && reset) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, sd);
      chk("stall_src", 32'(out_src), 32'(ss));
    end
    stall_pend = reset && out_valid && !out_ready;
    sd = out_data;
    ss = out_src;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("extra_word", out_data, 32'hDEADBEEF);
      end else begin
        e = q.pop_front();
        chk("word_data", out_data, e.data);
        chk("word_src", 32'(out_src), 32'(e.src));
        chk("word_last", 32'(out_last), 32'(e.last));
        if (e.cyc >= 0) chk("word_cycle", cyc, e.cyc);
      end
      nwords++;
    end
    if (done) done_cnt++;
  end

  task automatic push_dump(input int first_cyc);
    exp_t e;
    for (int i = 0; i < 96; i++) begin
      e.data = (i < 32) ? 32'(3 * i) : 32'h1000 + 32'(i - 32);
      e.src  = (i < 32) ? 2'd0 : 2'd1;
`ifdef DUMP_CHECKSUM_EN
      e.last = 1'b0;
`else
      e.last = (i == 95);
`endif
      e.cyc  = (first_cyc >= 0) ? first_cyc + i : -1;
      q.push_back(e);
    end
`ifdef DUMP_CHECKSUM_EN
    e.data = 32'h00040DB0;
    e.src  = 2'd2;
    e.last = 1'b1;
    e.cyc  = (first_cyc >= 0) ? first_cyc + 96 : -1;
    q.push_back(e);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 1000) begin
      @(posedge clk); #2;
      if (done) break;
      n++;
    end
    chk("done_timeout", 32'(n < 1000), 32'd1);
    chk("done_hold_cpu", 32'(hold_cpu), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_hold", 32'(hold_cpu), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
  endtask

  initial begin
    int d0, n, first;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    #2 check_reset_vals();
    #20 reset = 1'b1;

    // 1: basic dump, exact cycle of every word
    @(posedge clk); #1;
    first = cyc + 2;
    push_dump(first);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_after_start", 32'(hold_cpu), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done();
    chk("done_count_basic", done_cnt, d0 + 1);

    // 2: random backpressure
    mode = 1;
    push_dump(-1);
    d0 = done_cnt;
    pulse_start();
    wait_done();
    chk("done_count_bp", done_cnt, d0 + 1);

    // 3: start during MEM phase is ignored
    mode = 0;
    push_dump(-1);
    d0 = done_cnt;
    n = nwords;
    pulse_start();
    while (nwords < n + 50 && cyc < 20000) begin @(posedge clk); #2; end
    pulse_start();
    wait_done();
    repeat (3) @(posedge clk);
    chk("done_count_ignored", done_cnt, d0 + 1);
    chk("idle_after_ignored", 32'(busy), 32'd0);

    // 4: reset at word 40
    push_dump(-1);
    d0 = done_cnt;
    n = nwords;
    pulse_start();
    while (nwords < n + 40 && cyc < 20000) begin @(posedge clk); #2; end
    #1 reset = 1'b0;
    #1 check_reset_vals();
    q.delete();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    chk("no_done_on_reset", done_cnt, d0);
    @(posedge clk); #1;
    first = cyc + 2;
    push_dump(first);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("done_count_after_rst", done_cnt, d0 + 1);

    // 6: stall on final word
    mode = 2;
    out_ready = 1'b1;
    push_dump(-1);
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!(out_valid && out_last) && n < 500) begin @(posedge clk); #2; n++; end
    chk("last_seen", 32'(n < 500), 32'd1);
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      chk("stall_hold_cpu", 32'(hold_cpu), 32'd1);
      chk("stall_no_done", 32'(done), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk("stall_done_pulse", 32'(done), 32'd1);
    chk("stall_hold_drop", 32'(hold_cpu), 32'd0);
    @(posedge clk); #2;
    chk("stall_done_single", 32'(done), 32'd0);
    chk("stall_queue_empty", q.size(), 0);
    chk("done_count_stall", done_cnt, d0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mips_state_dumper.md
Name: mips_state_dumper

Overview:
Hardware counterpart of the simulation-only register/memory dump. On `start`, it freezes the single-cycle MIPS core and reads every register-file entry, then every data-memory word. It streams each word out on a valid/ready interface toward a debug/UART bridge. It sits beside the core, sharing the register file's debug read port and the data memory's debug read port.

Parameters:
- NUM_REGS, 32, register-file entries dumped (indices 0..NUM_REGS-1).
- DMEM_WORDS, 64, data-memory words dumped (word addresses 0..DMEM_WORDS-1); must be >= 1.
- DMEM_AW, 6, width of the data-memory word address; 2**DMEM_AW >= DMEM_WORDS.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted), same net as the core's reset.
- start, input, 1, request a dump; sampled only in IDLE.
- hold_cpu, output, 1, freezes the core's PC/write enables while high.
- busy, output, 1, high from leaving IDLE until DONE is exited.
- done, output, 1, one-cycle pulse when the dump completes.
- rf_addr, output, 5, register-file debug read address.
- rf_data, input, 32, combinational read data for rf_addr.
- dm_addr, output, DMEM_AW, data-memory debug word address.
- dm_data, input, 32, combinational read data for dm_addr.
- out_valid, output, 1, out_data holds a word.
- out_ready, input, 1, sink accepts the word in this cycle.
- out_data, output, 32, dumped word.
- out_src, output, 2, source of the word: 0 = register, 1 = memory, 2 = checksum.
- out_last, output, 1, marks the final word of the dump.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, idx=0, hold_cpu=0, busy=0, done=0, out_valid=0, out_data=0, out_src=0, out_last=0, rf_addr=0, dm_addr=0. Reset mid-dump abandons the dump immediately; no done pulse is produced.
- States are IDLE, REG, MEM, (SUM), DONE.
- IDLE:
  - If start=1, go to REG with idx=0, and set hold_cpu=1 and busy=1 from the next cycle.
  - start in any other state is ignored.
- Word pipeline:
  - The block holds a single output register.
  - "Slot free" means out_valid=0, or out_valid=1 and out_ready=1.
  - In REG or MEM with the slot free, it captures the read data at addr=idx into out_data, sets out_valid=1, sets out_src, and increments idx.
  - With the slot not free, idx, out_data, out_src and out_last hold stable. Words are never dropped or duplicated.
  - Throughput is 1 word/cycle while out_ready=1.
- Addressing:
  - rf_addr = idx[4:0] in REG, else 0.
  - dm_addr = idx[DMEM_AW-1:0] in MEM, else 0.
- Latency: start sampled at cycle N, the first word (reg 0) is valid at cycle N+2.
- REG -> MEM: when the word for idx=NUM_REGS-1 is captured, idx resets to 0.
- MEM -> DONE: when the word for idx=DMEM_WORDS-1 is captured (with out_last=1), go to DONE (or to SUM under the option).
- DONE:
  - Wait until the final word is handshaken (out_valid&&out_ready), then clear out_valid.
  - Pulse done=1 for exactly one cycle, drop hold_cpu and busy in that same cycle, and return to IDLE.
- Register 0 is dumped as whatever rf_data returns; the core guarantees it reads 0.
- out_last=1 only on the final word; out_last is 0 on every other word.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- When defined:
  - A 32-bit accumulator is cleared on start.
  - It adds every captured word, modulo 2^32.
  - After the last memory word, state SUM captures the accumulator as one extra word with out_src=2 and out_last=1.
  - The last memory word then carries out_last=0.
  - Total words = NUM_REGS + DMEM_WORDS + 1.
- When undefined: no accumulator and no SUM state; the last memory word carries out_last=1; total words = NUM_REGS + DMEM_WORDS.

Test Plan:
1. Basic dump:
   - Stimulus: rf model returns 3*addr, dm model returns 0x1000+addr, out_ready=1; pulse start.
   - Required response: 96 words in consecutive cycles starting 2 cycles after start. Words are 0,3,…,93 (out_src=0), then 0x1000…0x103F (out_src=1). out_last=1 only on 0x103F. done pulses once, then hold_cpu=0.
2. Backpressure: same stimulus with out_ready toggled 1/0 pseudo-randomly -> out_data and out_src are stable while out_valid=1 and out_ready=0; the same 96-word sequence is received with no gaps and no duplicates.
3. Ignored start: pulse start again during MEM -> no restart; sequence and word count unchanged; exactly one done pulse.
4. Reset mid-dump:
   - Stimulus: assert reset at word 40.
   - Required response: all outputs go to reset values asynchronously with no done pulse. A new start after release dumps from reg 0 again.
5. Checksum (DUMP_CHECKSUM_EN, stimulus of scenario 1) -> a 97th word with out_src=2 and out_last=1. Its value is sum(3*i, i=0..31) + sum(0x1000+i, i=0..63) = 1488 + 0x40000 + 2016 = 0x40DB0. Word 96 (0x103F) has out_last=0.
6. Stall on final word: hold out_ready=0 when out_last=1 -> DONE is held and hold_cpu stays 1. done pulses in the cycle after out_ready rises.
